data_mem_responder: RTL and testbench

- Word-addressed data memory that serves the load/store strobes (mem_read, mem_write) produced by the control path.
- Adds a programmable wait-state latency and a one-cycle completion pulse, so the datapath can stall on busy.
- On a load completion, read_data feeds the mem_to_reg writeback mux.
- Misaligned or conflicting requests are rejected with an error pulse and never touch storage.

---
 rtl/data_mem_responder_if.sv | 24 ++
 rtl/data_mem_responder.sv | 152 +++++++++++++++
 tb/tb_data_mem_responder.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// Load/store request bus between the control path (master) and the
// data memory responder (slave).
interface data_mem_responder_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  mem_read;
    logic                  mem_write;
    logic [31:0]           addr;
    logic [DATA_WIDTH-1:0] write_data;
    logic [DATA_WIDTH-1:0] read_data;
    logic                  busy;
    logic                  done;
    logic                  error;

    modport master (
        output mem_read, mem_write, addr, write_data,
        input  read_data, busy, done, error
    );

    modport slave (
        input  mem_read, mem_write, addr, write_data,
        output read_data, busy, done, error
    );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data memory with programmable wait states, a one-cycle
// done pulse per access and a one-cycle error pulse for rejected requests.
module data_mem_responder #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_BITS   = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_responder_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic       ZERO_WAIT = (WAIT_CYCLES == 0) ? 1'b1 : 1'b0;

    state_t                state_r;
    logic [3:0]            wait_cnt_r;
    logic                  op_write_r;
    logic [ADDR_BITS-1:0]  index_r;
    logic [DATA_WIDTH-1:0] wdata_r;
    logic [DATA_WIDTH-1:0] read_data_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  error_r;
    logic [DATA_WIDTH-1:0] mem_r [0:(2**ADDR_BITS)-1];

    logic                  req_s;
    logic                  reject_s;
    logic                  accept_s;
    logic                  enter_resp_s;
    logic                  is_write_s;
    logic                  commit_s;
    logic [ADDR_BITS-1:0]  idx_s;
    logic [DATA_WIDTH-1:0] wdata_s;
    logic                  unused_addr_s;

    // Upper address bits only select an alias of the same word.
    assign unused_addr_s = ^{1'b0, bus.addr[31:ADDR_BITS+2]};

    assign req_s    = bus.mem_read | bus.mem_write;
    assign reject_s = req_s & ((bus.mem_read & bus.mem_write) | (bus.addr[1:0] != 2'b00));
    assign accept_s = req_s & ~reject_s;

    // Decode the access that completes on this edge; a zero-wait access uses the live request.
    always_comb begin
        enter_resp_s = 1'b0;
        idx_s        = index_r;
        wdata_s      = wdata_r;
        is_write_s   = op_write_r;
        case (state_r)
            ST_IDLE: begin
                idx_s      = bus.addr[ADDR_BITS+1:2];
                wdata_s    = bus.write_data;
                is_write_s = bus.mem_write;
                if (accept_s && ZERO_WAIT) begin
                    enter_resp_s = 1'b1;
                end else begin
                    enter_resp_s = 1'b0;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_r == 4'd0) begin
                    enter_resp_s = 1'b1;
                end else begin
                    enter_resp_s = 1'b0;
                end
            end
            default: begin
                enter_resp_s = 1'b0;
            end
        endcase
    end

    // Reset must abort a pending store even though the array itself is not reset.
    assign commit_s = enter_resp_s & is_write_s & ~rst;

    // Storage array, written only on the edge entering RESP.
    always_ff @(posedge clk) begin
        if (commit_s) begin
            mem_r[idx_s] <= wdata_s;
        end
    end

    // Access sequencer with registered busy/done/error/read_data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            wait_cnt_r  <= 4'd0;
            op_write_r  <= 1'b0;
            index_r     <= '0;
            wdata_r     <= '0;
            read_data_r <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            error_r     <= 1'b0;
        end else begin
            done_r  <= 1'b0;
            error_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (reject_s) begin
                        error_r <= 1'b1;
                        busy_r  <= 1'b0;
                    end else if (accept_s) begin
                        op_write_r <= bus.mem_write;
                        index_r    <= bus.addr[ADDR_BITS+1:2];
                        wdata_r    <= bus.write_data;
                        busy_r     <= 1'b1;
                        if (ZERO_WAIT) begin
                            state_r <= ST_RESP;
                            done_r  <= 1'b1;
                        end else begin
                            state_r    <= ST_WAIT;
                            wait_cnt_r <= WAIT_INIT;
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt_r == 4'd0) begin
                        state_r <= ST_RESP;
                        done_r  <= 1'b1;
                    end else begin
                        wait_cnt_r <= wait_cnt_r - 4'd1;
                    end
                end
                ST_RESP: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
            if (enter_resp_s && !is_write_s) begin
                read_data_r <= mem_r[idx_s];
            end
        end
    end

    assign bus.read_data = read_data_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.error     = error_r;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance with two wait states,
// one with zero wait states, sharing a reset.
module tb_data_mem_responder;
    logic        clk;
    logic        rst;
    logic        sel;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] write_data;

    int passed;
    int total;

    typedef struct {
        logic        sel;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [19];

    data_mem_responder_if #(.DATA_WIDTH(32)) if2 ();
    data_mem_responder_if #(.DATA_WIDTH(32)) if0 ();

    assign if2.mem_read   = mem_read & ~sel;
    assign if2.mem_write  = mem_write & ~sel;
    assign if2.addr       = addr;
    assign if2.write_data = write_data;
    assign if0.mem_read   = mem_read & sel;
    assign if0.mem_write  = mem_write & sel;
    assign if0.addr       = addr;
    assign if0.write_data = write_data;

    data_mem_responder #(.DATA_WIDTH(32), .ADDR_BITS(8), .WAIT_CYCLES(2)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (if2.slave)
    );

    data_mem_responder #(.DATA_WIDTH(32), .ADDR_BITS(8), .WAIT_CYCLES(0)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0.slave)
    );

    logic        obs_busy;
    logic        obs_done;
    logic        obs_error;
    logic [31:0] obs_rd;

    assign obs_busy  = sel ? if0.busy      : if2.busy;
    assign obs_done  = sel ? if0.done      : if2.done;
    assign obs_error = sel ? if0.error     : if2.error;
    assign obs_rd    = sel ? if0.read_data : if2.read_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            passed++;
        end
    endtask

    // Caller is just past a negedge; issues one request and follows it to completion.
    task automatic apply_vec(input vec_t v, input int idx);
        int   lat;
        int   exp_lat;
        logic got_done;
        logic got_err;
        logic busy1;
        sel        = v.sel;
        mem_read   = v.rd;
        mem_write  = v.wr;
        addr       = v.addr;
        write_data = v.wdata;
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        lat      = 0;
        got_done = 1'b0;
        got_err  = 1'b0;
        busy1    = 1'b0;
        for (int n = 1; n <= 20 && lat == 0; n++) begin
            @(negedge clk);
            if (n == 1) busy1 = obs_busy;
            if (obs_done || obs_error) begin
                lat      = n;
                got_done = obs_done;
                got_err  = obs_error;
            end
        end
        exp_lat = v.err ? 1 : (v.sel ? 1 : 3);
        check($sformatf("v%0d latency", idx), 64'(lat), 64'(exp_lat));
        check($sformatf("v%0d error", idx), 64'(got_err), 64'(v.err));
        check($sformatf("v%0d done", idx), 64'(got_done), 64'(!v.err));
        check($sformatf("v%0d busy", idx), 64'(busy1), 64'(!v.err));
        check($sformatf("v%0d read_data", idx), 64'(obs_rd), 64'(v.exp_rd));
        @(negedge clk);
        check($sformatf("v%0d pulse_end", idx), 64'({obs_done, obs_error, obs_busy}), 64'd0);
        check($sformatf("v%0d rd_held", idx), 64'(obs_rd), 64'(v.exp_rd));
    endtask

    initial begin
        int   done_cnt;
        int   err_cnt;
        int   lat;
        vec_t v;

        passed     = 0;
        total      = 0;
        sel        = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        addr       = 32'h0;
        write_data = 32'h0;
        rst        = 1'b1;

        //            sel   rd    wr    addr           wdata          err   exp_rd
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'h0000_0000};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 32'h0000_0004, 32'h1234_5678, 1'b0, 32'h0000_0000};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0004, 32'h0000_0000, 1'b0, 32'h1234_5678};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 32'h0000_0008, 32'h1111_1111, 1'b0, 32'h1234_5678};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0006, 32'h0000_0000, 1'b1, 32'h1234_5678};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 32'h0000_0008, 32'hFFFF_FFFF, 1'b1, 32'h1234_5678};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0008, 32'h0000_0000, 1'b0, 32'h1111_1111};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 32'h0000_0404, 32'hA5A5_A5A5, 1'b0, 32'h1111_1111};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0004, 32'h0000_0000, 1'b0, 32'hA5A5_A5A5};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 32'h0000_0006, 32'hBADB_AD00, 1'b1, 32'hA5A5_A5A5};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'h0000_0000};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 32'h0000_0004, 32'h0000_0000, 1'b0, 32'hA5A5_A5A5};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 1'b0, 32'h0000_0000};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 32'h0000_0020, 32'h0000_0000, 1'b0, 32'hCAFE_F00D};
        vecs[14] = '{1'b1, 1'b0, 1'b1, 32'h0000_0024, 32'h0BAD_F00D, 1'b0, 32'hCAFE_F00D};
        vecs[15] = '{1'b1, 1'b1, 1'b0, 32'h0000_0024, 32'h0000_0000, 1'b0, 32'h0BAD_F00D};
        vecs[16] = '{1'b1, 1'b1, 1'b0, 32'h0000_0022, 32'h0000_0000, 1'b1, 32'h0BAD_F00D};
        vecs[17] = '{1'b1, 1'b1, 1'b0, 32'h0000_0020, 32'h0000_0000, 1'b0, 32'hCAFE_F00D};
        vecs[18] = '{1'b1, 1'b0, 1'b1, 32'h0000_0420, 32'h7777_0000, 1'b0, 32'hCAFE_F00D};

        // Reset state of both instances.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst busy2", 64'(if2.busy), 64'd0);
        check("rst done2", 64'(if2.done), 64'd0);
        check("rst error2", 64'(if2.error), 64'd0);
        check("rst rd2", 64'(if2.read_data), 64'd0);
        check("rst busy0", 64'(if0.busy), 64'd0);
        check("rst rd0", 64'(if0.read_data), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 19; i++) begin
            apply_vec(vecs[i], i);
        end

        // Zero-wait: the store above went to 0x420, aliasing 0x20.
        v = '{1'b1, 1'b1, 1'b0, 32'h0000_0020, 32'h0, 1'b0, 32'h7777_0000};
        apply_vec(v, 19);

        // Store strobe presented while a load is in flight must be dropped.
        sel       = 1'b0;
        mem_read  = 1'b1;
        addr      = 32'h0000_0008;
        @(posedge clk);
        #1;
        mem_read = 1'b0;
        @(negedge clk);
        mem_write  = 1'b1;
        write_data = 32'h0000_0001;
        @(posedge clk);
        #1;
        mem_write = 1'b0;
        done_cnt  = 0;
        err_cnt   = 0;
        lat       = 0;
        for (int n = 2; n <= 9; n++) begin
            @(negedge clk);
            if (if2.done) begin
                done_cnt++;
                if (lat == 0) lat = n;
            end
            if (if2.error) err_cnt++;
        end
        check("busy_ign done_count", 64'(done_cnt), 64'd1);
        check("busy_ign error_count", 64'(err_cnt), 64'd0);
        check("busy_ign latency", 64'(lat), 64'd3);
        check("busy_ign read_data", 64'(if2.read_data), 64'h1111_1111);
        v = '{1'b0, 1'b1, 1'b0, 32'h0000_0008, 32'h0, 1'b0, 32'h1111_1111};
        apply_vec(v, 20);

        // Reset in the middle of a store's wait states.
        sel        = 1'b0;
        mem_write  = 1'b1;
        addr       = 32'h0000_0010;
        write_data = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        mem_write = 1'b0;
        @(negedge clk);
        check("midrst busy_before", 64'(if2.busy), 64'd1);
        rst = 1'b1;
        #1;
        check("midrst busy", 64'(if2.busy), 64'd0);
        check("midrst done", 64'(if2.done), 64'd0);
        check("midrst rd", 64'(if2.read_data), 64'd0);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check($sformatf("midrst hold%0d", n), 64'({if2.busy, if2.done}), 64'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("midrst no_done_after", 64'({if2.busy, if2.done, if2.error}), 64'd0);
        v = '{1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b0, 32'h0000_0000};
        apply_vec(v, 21);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
